// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the RV32I instruction fetch path
package rv32i_pkg;

    typedef enum logic {
        FETCH,
        FAULT
    } fetch_state_e;

    typedef enum logic [1:0] {
        P0,
        P1,
        P2
    } mem_phase_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    function automatic mem_phase_e next_phase(input mem_phase_e p);
        case (p)
            P0:      return P1;
            P1:      return P2;
            default: return P0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// rtl/rv32i_fetch_unit_if.sv - instruction memory read bus, decode handshake and redirect port
interface rv32i_fetch_unit_if;

    logic        o_mem_rd_en;
    logic [31:0] o_mem_rd_addr;
    logic [31:0] i_mem_rd_data;
    logic        i_mem_rd_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_fetch_fault;

    modport master (
        output o_mem_rd_en, o_mem_rd_addr, o_instr, o_instr_pc, o_instr_valid, o_fetch_fault,
        input  i_mem_rd_data, i_mem_rd_valid, i_instr_ready, i_redirect_valid, i_redirect_pc
    );

    modport slave (
        input  o_mem_rd_en, o_mem_rd_addr, o_instr, o_instr_pc, o_instr_valid, o_fetch_fault,
        output i_mem_rd_data, i_mem_rd_valid, i_instr_ready, i_redirect_valid, i_redirect_pc
    );

endinterface

// File: rtl/rv32i_fetch_slot.sv
// rtl/rv32i_fetch_slot.sv - single-entry valid/ready output register with flush
module rv32i_fetch_slot (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic [31:0] i_pc,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic [31:0] o_pc,
    output logic        o_free
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_q, pc_d;

    // Flush wins over a same-cycle load or consume.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
            pc_d    = i_pc;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_pc    = pc_q;
    assign o_free  = !valid_q || i_ready;

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rtl/rv32i_fetch_unit.sv - PC, 3-phase imem read window tracking and decode slot; RV32I_FETCH_MISALIGN_EN adds FAULT
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          IMEM_ADDR_BITS = 9
) (
    input logic                 i_clk,
    input logic                 i_rst,
    rv32i_fetch_unit_if.master  fetch_if
);

    if (IMEM_ADDR_BITS < 3 || IMEM_ADDR_BITS > 32) begin : g_bad_imem_bits
        $error("IMEM_ADDR_BITS must be in 3..32");
    end

    fetch_state_e state_q, state_d;
    mem_phase_e   phase_q, phase_d;
    logic [31:0]  pc_q, pc_d;
    logic         dirty_q, dirty_d;
    logic         rd_en_q, rd_en_d;
    logic         mem_err_q, mem_err_d;
    logic [31:0]  target;
    logic         redirect;
    logic         load;
    logic         slot_free;

    always_comb begin
        redirect  = fetch_if.i_redirect_valid;
        phase_d   = next_phase(phase_q);
        state_d   = state_q;
        pc_d      = pc_q;
        dirty_d   = dirty_q;
`ifdef RV32I_FETCH_MISALIGN_EN
        target = fetch_if.i_redirect_pc;
        if (redirect) begin
            state_d = (target[1:0] != 2'b00) ? FAULT : FETCH;
        end
`else
        target = fetch_if.i_redirect_pc & ~32'h3;
`endif
        // A response is only trusted if the address held still for its whole window.
        load = (state_q == FETCH) && (phase_q == P2) && fetch_if.i_mem_rd_valid
               && !dirty_q && !redirect && slot_free;
        if (redirect) begin
            pc_d = target;
        end else if (load) begin
            pc_d = pc_q + INSTR_BYTES;
        end
        if (phase_q == P2) begin
            dirty_d = 1'b0;
        end else if (redirect) begin
            dirty_d = 1'b1;
        end
        rd_en_d   = (state_d == FETCH);
        mem_err_d = mem_err_q | (fetch_if.i_mem_rd_valid && (phase_q != P2));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= FETCH;
            phase_q   <= P0;
            pc_q      <= RESET_PC;
            dirty_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pc_q      <= pc_d;
            dirty_q   <= dirty_d;
            rd_en_q   <= rd_en_d;
            mem_err_q <= mem_err_d;
        end
    end

    rv32i_fetch_slot u_slot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (redirect),
        .i_load  (load),
        .i_data  (fetch_if.i_mem_rd_data),
        .i_pc    (pc_q),
        .i_ready (fetch_if.i_instr_ready),
        .o_valid (fetch_if.o_instr_valid),
        .o_data  (fetch_if.o_instr),
        .o_pc    (fetch_if.o_instr_pc),
        .o_free  (slot_free)
    );

    assign fetch_if.o_mem_rd_en   = rd_en_q;
    assign fetch_if.o_mem_rd_addr = {pc_q[31:2], 2'b00};
`ifdef RV32I_FETCH_MISALIGN_EN
    assign fetch_if.o_fetch_fault = (state_q == FAULT);
`else
    assign fetch_if.o_fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb/tb_rv32i_fetch_unit.sv - directed bench for rv32i_fetch_unit with a 3-phase memory model
module tb_rv32i_fetch_unit;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32i_fetch_unit_if bus ();

    rv32i_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .IMEM_ADDR_BITS (9)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .fetch_if (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    int          bph    = 0;
    logic [31:0] lat    = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return NOP_INSTR;
            32'h0000_0004: return 32'h0050_0093;
            default:       return a ^ 32'h1357_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cycle, got, exp);
        end
    endtask

    // Memory sequencer: latches the address at P0, answers at P2.
    task automatic drive_mem();
        if (bph == 0) lat = bus.o_mem_rd_addr;
        bus.i_mem_rd_valid = (bph == 2);
        bus.i_mem_rd_data  = (bph == 2) ? mem_word(lat) : 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        bph = (bph == 2) ? 0 : bph + 1;
        drive_mem();
    endtask

    task automatic tick_to(input int n);
        while (cycle < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_mem_rd_valid   = 1'b0;
        bus.i_redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_rd_en", bus.o_mem_rd_en, 32'd0);
        check("rst_addr", bus.o_mem_rd_addr, 32'h0);
        check("rst_instr", bus.o_instr, 32'h0);
        check("rst_instr_pc", bus.o_instr_pc, 32'h0);
        check("rst_valid", bus.o_instr_valid, 32'd0);
        check("rst_fault", bus.o_fetch_fault, 32'd0);
        rst   = 1'b0;
        cycle = 0;
        bph   = 0;
        drive_mem();
    endtask

    task automatic redirect(input logic [31:0] t);
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = t;
        tick();
        bus.i_redirect_valid = 1'b0;
    endtask

    initial begin
        bus.i_instr_ready    = 1'b1;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = 32'h0;
        bus.i_mem_rd_valid   = 1'b0;
        bus.i_mem_rd_data    = 32'h0;

        // Streaming with ready held high
        do_reset();
        tick_to(1);
        check("t1_rd_en", bus.o_mem_rd_en, 32'd1);
        tick_to(2);
        check("t1_valid_c2", bus.o_instr_valid, 32'd0);
        check("t1_addr_c2", bus.o_mem_rd_addr, 32'h0);
        tick_to(3);
        check("t1_valid_c3", bus.o_instr_valid, 32'd1);
        check("t1_instr_c3", bus.o_instr, 32'h0000_0013);
        check("t1_pc_c3", bus.o_instr_pc, 32'h0);
        check("t1_addr_c3", bus.o_mem_rd_addr, 32'h4);
        tick_to(5);
        check("t1_valid_c5", bus.o_instr_valid, 32'd0);
        tick_to(6);
        check("t1_valid_c6", bus.o_instr_valid, 32'd1);
        check("t1_instr_c6", bus.o_instr, 32'h0050_0093);
        check("t1_pc_c6", bus.o_instr_pc, 32'h4);
        check("t1_addr_c6", bus.o_mem_rd_addr, 32'h8);

        // Back-pressure: slot held, P2 responses at 5 and 8 dropped
        bus.i_instr_ready = 1'b0;
        do_reset();
        tick_to(3);
        check("t2_valid_c3", bus.o_instr_valid, 32'd1);
        tick_to(9);
        check("t2_valid_c9", bus.o_instr_valid, 32'd1);
        check("t2_instr_c9", bus.o_instr, 32'h0000_0013);
        check("t2_pc_c9", bus.o_instr_pc, 32'h0);
        check("t2_addr_c9", bus.o_mem_rd_addr, 32'h4);
        tick_to(10);
        bus.i_instr_ready = 1'b1;
        tick_to(11);
        check("t2_valid_c11", bus.o_instr_valid, 32'd0);
        tick_to(12);
        check("t2_valid_c12", bus.o_instr_valid, 32'd1);
        check("t2_instr_c12", bus.o_instr, 32'h0050_0093);
        check("t2_pc_c12", bus.o_instr_pc, 32'h4);
        check("t2_addr_c12", bus.o_mem_rd_addr, 32'h8);

        // Redirect to 0x40 during P1 of the 0x8 window, slot occupied
        bus.i_instr_ready = 1'b0;
        tick_to(13);
        check("t3_hold_pc", bus.o_instr_pc, 32'h4);
        redirect(32'h0000_0040);
        bus.i_instr_ready = 1'b1;
        check("t3_flush", bus.o_instr_valid, 32'd0);
        check("t3_addr", bus.o_mem_rd_addr, 32'h40);
        for (int c = 15; c <= 17; c++) begin
            tick_to(c);
            check("t3_no_stale", bus.o_instr_valid, 32'd0);
        end
        tick_to(18);
        check("t3_valid", bus.o_instr_valid, 32'd1);
        check("t3_pc", bus.o_instr_pc, 32'h40);
        check("t3_instr", bus.o_instr, mem_word(32'h40));

        // Redirect coincident with a P2 response, target wraps
        tick_to(20);
        redirect(32'hFFFF_FFFC);
        check("t4_valid", bus.o_instr_valid, 32'd0);
        check("t4_addr", bus.o_mem_rd_addr, 32'hFFFF_FFFC);
        tick_to(23);
        check("t4_valid_c23", bus.o_instr_valid, 32'd0);
        tick_to(24);
        check("t5_valid", bus.o_instr_valid, 32'd1);
        check("t5_pc", bus.o_instr_pc, 32'hFFFF_FFFC);
        check("t5_instr", bus.o_instr, mem_word(32'hFFFF_FFFC));
        check("t5_wrap_addr", bus.o_mem_rd_addr, 32'h0);

        // Misaligned redirect
        redirect(32'h0000_0042);
`ifdef RV32I_FETCH_MISALIGN_EN
        check("t6_fault", bus.o_fetch_fault, 32'd1);
        check("t6_rd_en", bus.o_mem_rd_en, 32'd0);
        check("t6_valid", bus.o_instr_valid, 32'd0);
        tick_to(27);
        check("t6_fault_held", bus.o_fetch_fault, 32'd1);
        check("t6_rd_en_held", bus.o_mem_rd_en, 32'd0);
        check("t6_valid_held", bus.o_instr_valid, 32'd0);
        redirect(32'h0000_0044);
        check("t6_fault_clr", bus.o_fetch_fault, 32'd0);
        check("t6_rd_en_back", bus.o_mem_rd_en, 32'd1);
        check("t6_addr", bus.o_mem_rd_addr, 32'h44);
        tick_to(32);
        check("t6_valid_c32", bus.o_instr_valid, 32'd0);
        tick_to(33);
        check("t6_resume_valid", bus.o_instr_valid, 32'd1);
        check("t6_resume_pc", bus.o_instr_pc, 32'h44);
        check("t6_resume_instr", bus.o_instr, mem_word(32'h44));
`else
        check("t6_fault", bus.o_fetch_fault, 32'd0);
        check("t6_rd_en", bus.o_mem_rd_en, 32'd1);
        check("t6_addr_masked", bus.o_mem_rd_addr, 32'h40);
        check("t6_valid", bus.o_instr_valid, 32'd0);
        tick_to(29);
        check("t6_valid_c29", bus.o_instr_valid, 32'd0);
        tick_to(30);
        check("t6_masked_valid", bus.o_instr_valid, 32'd1);
        check("t6_masked_pc", bus.o_instr_pc, 32'h40);
        check("t6_masked_instr", bus.o_instr, mem_word(32'h40));
`endif

        // Reset in the middle of a window
        tick();
        do_reset();
        tick_to(3);
        check("t7_valid", bus.o_instr_valid, 32'd1);
        check("t7_instr", bus.o_instr, NOP_INSTR);
        check("t7_pc", bus.o_instr_pc, 32'h0);
        check("mem_phase_err", dut.mem_err_q, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_fetch_unit.md
Name: rv32i_fetch_unit

Overview:
Instruction-fetch initiator for the multicycle RV32I core. It drives the read side of the instruction memory: read enable, word address, and the 32-bit response, which is valid one cycle in every three. It also maintains the PC and presents fetched instructions to decode over a valid/ready handshake. It accepts PC redirects from execute (branch/jump) and guarantees that no stale instruction is delivered after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_ADDR_BITS, 9, number of low PC bits meaningful to instruction memory; PC bits above this are still held and reported.

Ports:
i_clk  in  1  core clock
i_rst  in  1  synchronous active-high reset
o_mem_rd_en  out  1  instruction memory read enable
o_mem_rd_addr  out  32  byte address of word being fetched
i_mem_rd_data  in  32  memory read data
i_mem_rd_valid  in  1  memory response strobe; one cycle in every three
o_instr  out  32  instruction to decode
o_instr_pc  out  32  PC of o_instr
o_instr_valid  out  1  instruction slot full
i_instr_ready  in  1  decode accepts slot this cycle
i_redirect_valid  in  1  load new PC
i_redirect_pc  in  32  redirect target
o_fetch_fault  out  1  misaligned-target flag; only with the optional feature, tied 0 otherwise

Behaviour:
- Clock is i_clk; reset i_rst is synchronous and active-high.
- Reset values:
  - pc = RESET_PC; o_mem_rd_en = 0; o_mem_rd_addr = RESET_PC.
  - o_instr = 0; o_instr_pc = 0; o_instr_valid = 0; o_fetch_fault = 0.
  - Phase counter = P0.
- Phase counter: mod-3 counter mirroring the memory read sequencer (P0 -> P1 -> P2 -> P0), free-running from reset.
  - Memory and fetch unit share i_rst, so both start at P0.
  - i_mem_rd_valid is expected only in P2. A valid in any other phase sets an internal sticky error bit, which is visible for verification only.
- o_mem_rd_addr = {pc[31:2], 2'b00}. o_mem_rd_en = 1 from the first cycle after reset release, except in FAULT.
- Window rule: a response at P2 is clean only if o_mem_rd_addr was unchanged across the P0, P1 and P2 cycles of that window. A window_dirty flag is cleared entering P0 and set on any PC change during P0/P1.
- States:
  - FETCH: waiting for P2.
    - On P2 with a clean response and the slot free (or freed this cycle by ready): load o_instr = i_mem_rd_data, o_instr_pc = pc, o_instr_valid = 1; pc += 4 at the same edge.
    - On P2 with the slot occupied and not being consumed: drop the response, keep pc, refetch next window.
    - On a dirty response: drop it, keep the current (new) pc.
  - FAULT (optional feature only): o_mem_rd_en = 0; leaves only on a valid redirect.
- Handshake:
  - Slot is consumed when o_instr_valid && i_instr_ready.
  - o_instr and o_instr_pc are held stable while valid && !ready.
  - Load and consume in the same cycle are allowed (back-to-back).
- Redirect (highest priority):
  - pc <= i_redirect_pc at the next edge.
  - o_instr_valid <= 0 at the same edge, discarding any unconsumed slot even if ready was high that cycle.
  - The in-flight window is marked dirty.
  - First post-redirect instruction appears at the earliest P2 whose whole window saw the new address, 3-5 cycles after the redirect.
- Redirect and a P2 response in the same cycle: the response is dropped.
- PC arithmetic is 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
- Reset mid-window: all state returns to reset values and the phase counter returns to P0; any partial response is ignored.

Optional Feature:
RV32I_FETCH_MISALIGN_EN:
- Defined: a redirect with i_redirect_pc[1:0] != 0 enters FAULT.
  - pc takes the target unmasked; o_fetch_fault = 1 (held).
  - o_mem_rd_en = 0; o_instr_valid = 0.
  - The next aligned redirect clears o_fetch_fault and resumes FETCH.
- Undefined: pc[1:0] are forced to 0 on redirect; o_fetch_fault is tied 0; no FAULT state.

Decomposition:
- Package rv32i_pkg holds:
  - fetch_state_e {FETCH, FAULT};
  - mem_phase_e {P0, P1, P2};
  - the constant INSTR_BYTES = 4;
  - the NOP encoding 32'h0000_0013, for bench use.
- One sub-module is natural: rv32i_fetch_slot, the single-entry valid/ready output register with flush input.

Test Plan:
- Reset, then ready held 1 with memory model holding 0x13 at 0x0, 0x00500093 at 0x4: o_instr_valid rises at cycle 3 with instr 0x13, pc 0x0; next at cycle 6 with 0x00500093, pc 0x4; addresses 0x0, 0x4, 0x8 in sequence.
- Ready low for 7 cycles after the first instruction: o_instr/o_instr_pc held at 0x13/0x0; the next two P2 responses are dropped; pc stays 0x4 until the slot is consumed.
- Redirect to 0x40 in P1 of the window for 0x8: the 0x8 response is dropped, slot flushed; next instruction delivered has pc 0x40, no instruction with pc 0x8 is ever delivered.
- Redirect coincident with P2 valid and ready=1: response dropped; o_instr_valid=0 next cycle; pc = target.
- Redirect to 0xFFFF_FFFC: after delivery, pc wraps to 0x0 and the next o_mem_rd_addr = 0x0.
- With RV32I_FETCH_MISALIGN_EN: redirect to 0x42 -> o_fetch_fault=1, o_mem_rd_en=0 within 1 cycle; redirect to 0x44 -> fault clears, fetch resumes at 0x44.
